// File: rtl/store_monitor.sv
// Judges a core's store stream: a store of PASS_DATA to PASS_ADR passes, any
// other store (except to IGNORE_ADR) fails, and silence for TIMEOUT cycles times out.
module store_monitor #(
    parameter logic [31:0] PASS_ADR   = 32'd100,
    parameter logic [31:0] PASS_DATA  = 32'd7,
    parameter logic [31:0] IGNORE_ADR = 32'd96,
    parameter logic [31:0] TIMEOUT    = 32'd1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout,
    output logic [15:0] write_count,
    output logic [31:0] cycle_count,
    output logic [31:0] fail_adr,
    output logic [31:0] fail_data
);

    typedef enum logic [1:0] {RUN, PASS, FAIL, TOUT} state_t;

    localparam logic [31:0] LAST_CYCLE = TIMEOUT - 32'd1;

    state_t state, nextState;

    // A store verdict wins over the timeout when both land on the same edge.
    always_comb begin
        nextState = state;
        if (state == RUN) begin
            if (MemWrite) begin
                if (DataAdr == PASS_ADR && WriteData == PASS_DATA)
                    nextState = PASS;
                else if (DataAdr != IGNORE_ADR)
                    nextState = FAIL;
            end else if (cycle_count == LAST_CYCLE) begin
                nextState = TOUT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            done        <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            timeout     <= 1'b0;
            write_count <= 16'd0;
            cycle_count <= 32'd0;
            fail_adr    <= 32'd0;
            fail_data   <= 32'd0;
        end else begin
            state   <= nextState;
            done    <= (nextState != RUN);
            pass    <= (nextState == PASS);
            fail    <= (nextState == FAIL) || (nextState == TOUT);
            timeout <= (nextState == TOUT);
            if (state == RUN) begin
                if (cycle_count != 32'hFFFF_FFFF)
                    cycle_count <= cycle_count + 32'd1;
                if (MemWrite && write_count != 16'hFFFF)
                    write_count <= write_count + 16'd1;
                if (nextState == FAIL) begin
                    fail_adr  <= DataAdr;
                    fail_data <= WriteData;
                end
            end
        end
    end

endmodule

// File: tb/tb_store_monitor.sv
// Directed bench for store_monitor: one instance with default parameters and
// one with TIMEOUT=10; expected snapshots are queued at drive time and popped at sample time.
module tb_store_monitor;

    typedef struct {
        logic        done, pass, fail, tmo;
        logic [15:0] wc;
        logic [31:0] cc, fa, fd;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstA = 1'b1, mwA = 1'b0, rstB = 1'b1, mwB = 1'b0;
    logic [31:0] adrA = '0, datA = '0, adrB = '0, datB = '0;

    logic        doneA, passA, failA, tmoA, doneB, passB, failB, tmoB;
    logic [15:0] wcA, wcB;
    logic [31:0] ccA, faA, fdA, ccB, faB, fdB;

    store_monitor dutA (
        .clk(clk), .reset(rstA), .MemWrite(mwA), .DataAdr(adrA), .WriteData(datA),
        .done(doneA), .pass(passA), .fail(failA), .timeout(tmoA),
        .write_count(wcA), .cycle_count(ccA), .fail_adr(faA), .fail_data(fdA)
    );

    store_monitor #(.TIMEOUT(32'd10)) dutB (
        .clk(clk), .reset(rstB), .MemWrite(mwB), .DataAdr(adrB), .WriteData(datB),
        .done(doneB), .pass(passB), .fail(failB), .timeout(tmoB),
        .write_count(wcB), .cycle_count(ccB), .fail_adr(faB), .fail_data(fdB)
    );

    exp_t expQ[$];
    int   checks = 0;
    int   errors = 0;

    function automatic exp_t mk(input logic d, p, f, t, input logic [15:0] wc,
                                input logic [31:0] cc, fa, fd);
        exp_t e;
        e.done = d; e.pass = p; e.fail = f; e.tmo = t;
        e.wc = wc; e.cc = cc; e.fa = fa; e.fd = fd;
        return e;
    endfunction

    // Drive one cycle on the selected instance (the other is parked in reset)
    // and sample just after the rising edge.
    task automatic step(input logic selB, input logic rst, input logic mw,
                        input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        if (selB) begin
            rstB = rst; mwB = mw; adrB = a; datB = d;
            rstA = 1'b1; mwA = 1'b0;
        end else begin
            rstA = rst; mwA = mw; adrA = a; datA = d;
            rstB = 1'b1; mwB = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check(input logic selB, input string tag);
        exp_t e;
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL %s: observed empty scoreboard expected an entry", tag);
            return;
        end
        e = expQ.pop_front();
        cmp({tag, ".done"},    selB ? doneB : doneA, {31'd0, e.done});
        cmp({tag, ".pass"},    selB ? passB : passA, {31'd0, e.pass});
        cmp({tag, ".fail"},    selB ? failB : failA, {31'd0, e.fail});
        cmp({tag, ".timeout"}, selB ? tmoB  : tmoA,  {31'd0, e.tmo});
        cmp({tag, ".wc"},      {16'd0, selB ? wcB : wcA}, {16'd0, e.wc});
        cmp({tag, ".cc"},      selB ? ccB : ccA, e.cc);
        cmp({tag, ".fadr"},    selB ? faB : faA, e.fa);
        cmp({tag, ".fdata"},   selB ? fdB : fdA, e.fd);
    endtask

    initial begin
        // Instance A: default parameters
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        expQ.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));        check(0, "reset");

        step(0, 0, 1, 96, 3);
        expQ.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0));        check(0, "ign1");
        step(0, 0, 1, 96, 5);
        expQ.push_back(mk(0, 0, 0, 0, 2, 2, 0, 0));        check(0, "ign2");
        step(0, 0, 1, 100, 7);
        expQ.push_back(mk(1, 1, 0, 0, 3, 3, 0, 0));        check(0, "pass");
        step(0, 0, 1, 104, 9);
        expQ.push_back(mk(1, 1, 0, 0, 3, 3, 0, 0));        check(0, "passHeld");

        step(0, 1, 0, 0, 0);
        expQ.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));        check(0, "rstInPass");
        step(0, 0, 1, 100, 7);
        expQ.push_back(mk(1, 1, 0, 0, 1, 1, 0, 0));        check(0, "rePass");

        step(0, 1, 0, 0, 0);
        step(0, 0, 1, 100, 8);
        expQ.push_back(mk(1, 0, 1, 0, 1, 1, 100, 8));      check(0, "badData");
        step(0, 0, 1, 100, 7);
        expQ.push_back(mk(1, 0, 1, 0, 1, 1, 100, 8));      check(0, "failHeld");

        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 104, 7);
        expQ.push_back(mk(1, 0, 1, 0, 1, 2, 104, 7));      check(0, "badAdr");

        // A store presented while reset is high must leave no trace
        step(0, 1, 1, 104, 7);
        expQ.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));        check(0, "storeInRst");

        // Instance B: TIMEOUT=10, idle until the budget runs out
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 0);
        expQ.push_back(mk(0, 0, 0, 0, 0, 9, 0, 0));        check(1, "preTout");
        step(1, 0, 0, 0, 0);
        expQ.push_back(mk(1, 0, 1, 1, 0, 10, 0, 0));       check(1, "tout");
        step(1, 0, 1, 100, 7);
        step(1, 0, 0, 0, 0);
        expQ.push_back(mk(1, 0, 1, 1, 0, 10, 0, 0));       check(1, "toutHeld");

        // Store verdict beats the timeout on the same edge
        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 0);
        step(1, 0, 1, 100, 7);
        expQ.push_back(mk(1, 1, 0, 0, 1, 10, 0, 0));       check(1, "passAtTout");

        step(1, 1, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 0);
        step(1, 0, 1, 200, 1);
        expQ.push_back(mk(1, 0, 1, 0, 1, 10, 200, 1));     check(1, "failAtTout");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/store_monitor.md
STORE_MONITOR -- requirements
Module: store_monitor

Interface
REQ-001 The block SHALL have parameter PASS_ADR, default 32'd100, the store address that signals a passing program.
REQ-002 The block SHALL have parameter PASS_DATA, default 32'd7, the store data required at PASS_ADR for a pass.
REQ-003 The block SHALL have parameter IGNORE_ADR, default 32'd96, a scratch address whose stores are counted but never judged.
REQ-004 The block SHALL have parameter TIMEOUT, default 32'd1000, the cycle budget before a timeout verdict; TIMEOUT SHALL be at least 1.
REQ-005 The block SHALL use a single clock and a synchronous, active-high reset on the ports listed below.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 reset  input  1  synchronous active-high reset.
REQ-008 MemWrite  input  1  store strobe from the core's data port.
REQ-009 DataAdr  input  32  store byte address.
REQ-010 WriteData  input  32  store data.
REQ-011 done  output  1  a verdict has been reached; sticky.
REQ-012 pass  output  1  verdict is pass.
REQ-013 fail  output  1  verdict is bad store or timeout.
REQ-014 timeout  output  1  verdict is timeout.
REQ-015 write_count  output  16  number of stores sampled in RUN.
REQ-016 cycle_count  output  32  number of clock cycles spent in RUN.
REQ-017 fail_adr  output  32  DataAdr of the store that caused FAIL.
REQ-018 fail_data  output  32  WriteData of the store that caused FAIL.

Function
REQ-019 The block SHALL implement four states: RUN, PASS, FAIL, TOUT; the state SHALL be RUN after reset.
REQ-020 In RUN, the block SHALL sample MemWrite, DataAdr and WriteData on each rising edge with reset low.
REQ-021 A sampled store SHALL be judged against PASS_ADR and PASS_DATA by full 32-bit equality.
REQ-022 A sampled store with DataAdr==PASS_ADR and WriteData==PASS_DATA SHALL move RUN to PASS.
REQ-023 A sampled store with DataAdr==IGNORE_ADR SHALL keep the state in RUN.
REQ-024 Any other sampled store SHALL move RUN to FAIL; this includes a store to PASS_ADR with wrong data.
REQ-025 On the RUN-to-FAIL transition, fail_adr and fail_data SHALL load the offending store's address and data.
REQ-026 In RUN with no store sampled, the state SHALL move to TOUT when cycle_count equals TIMEOUT-1.
REQ-027 If a store and the timeout condition occur in the same cycle, the store verdict (PASS or FAIL) SHALL take priority over TOUT.
REQ-028 PASS, FAIL and TOUT SHALL be terminal and held until reset; inputs SHALL be ignored in these states.
REQ-029 Outputs SHALL be registered; a verdict SHALL appear on done, pass and fail in the cycle after the edge that sampled the deciding store.
REQ-030 done SHALL be 1 in PASS, FAIL and TOUT; pass SHALL be 1 only in PASS; fail SHALL be 1 in FAIL or TOUT; timeout SHALL be 1 only in TOUT.
REQ-031 write_count SHALL increment on every store sampled in RUN, including the deciding store, and SHALL saturate at 16'hFFFF.
REQ-032 cycle_count SHALL increment on every edge in RUN, SHALL saturate at 32'hFFFFFFFF, and SHALL freeze in terminal states.

Reset
REQ-033 When reset is high at a rising edge, the state SHALL become RUN, and done, pass, fail and timeout SHALL become 0.
REQ-034 When reset is high at a rising edge, write_count, cycle_count, fail_adr and fail_data SHALL become 0.
REQ-035 Reset asserted mid-run or in any terminal state SHALL restart monitoring from the next edge after reset falls.
REQ-036 Inputs sampled while reset is high SHALL have no effect.

Verification
REQ-037 Reset for 2 cycles, stores (96,3), (96,5), (100,7) -> pass=1, done=1, fail=0 the cycle after the third store; write_count=3.
REQ-038 Store (100,8) -> fail=1, timeout=0, fail_adr=100, fail_data=8; a later store (100,7) leaves the state unchanged.
REQ-039 Store (104,7) -> fail=1, fail_adr=104, fail_data=7, write_count=1.
REQ-040 TIMEOUT=10, no stores -> timeout=1 and fail=1 after the 10th RUN edge; cycle_count=10 and then held.
REQ-041 TIMEOUT=10, store (100,7) on the 10th RUN edge -> pass=1, timeout=0.
REQ-042 Reset pulsed in PASS -> all outputs 0 next cycle; store (100,7) afterwards -> pass again, write_count=1.
